// File: rtl/sram_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_initiator
// Purpose  : Single-request SRAM bus initiator. Accepts one host request at a
//            time and turns it into a one-cycle write or read access on an
//            asynchronous-style SRAM bus with a shared bidirectional data bus.
//            A completion pulse (rsp_valid) follows every access; read data
//            is held on rsp_rdata until the next read completes.
// Config   : SRAM_TURNAROUND_EN - when defined, every read is followed by one
//            idle TURN cycle (controls low, bus released) before IDLE, so the
//            device has time to release the data bus.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid/ready   - host request handshake
//            req_we/addr/wdata - request type, word address, write data
//            rsp_valid         - one-cycle completion pulse
//            rsp_rdata         - last read data
//            busy              - high whenever not in IDLE
//            mem_addr          - memory address (registered, held in IDLE)
//            mem_data          - bidirectional data bus (driven only in WR)
//            mem_cs/we/oe      - registered chip select / write / output en.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_initiator #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;

    logic                  r_mem_cs;
    logic                  r_mem_we;
    logic                  r_mem_oe;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = req_we ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RD: begin
`ifdef SRAM_TURNAROUND_EN
                w_state_nxt = ST_TURN;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered memory-side outputs and response path.
    // Controls are decoded from the *next* state so that they are valid
    // for exactly the cycle the FSM spends in WR or RD, with no
    // combinational path from the request inputs to the memory pins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_oe    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_mem_cs <= (w_state_nxt == ST_WR) || (w_state_nxt == ST_RD);
            r_mem_we <= (w_state_nxt == ST_WR);
            r_mem_oe <= (w_state_nxt == ST_RD);
            if (w_accept) begin
                r_mem_addr  <= req_addr;
                r_mem_wdata <= req_wdata;
            end
            // Completion pulse in the cycle after the access cycle.
            r_rsp_valid <= (r_state == ST_WR) || (r_state == ST_RD);
            // Device drives the bus during RD; capture it as RD ends.
            if (r_state == ST_RD) begin
                r_rsp_rdata <= mem_data;
            end
        end
    end

    // The write strobe doubles as the bus drive enable: the initiator only
    // owns the data bus while a write is on the pins.
    assign mem_data  = r_mem_we ? r_mem_wdata : {DATA_WIDTH{1'bz}};

    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_oe    = r_mem_oe;
    assign mem_addr  = r_mem_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_initiator
// Purpose  : Self-checking bench for sram_bus_initiator. A behavioural SRAM
//            device answers on the shared bus; a separate reference array
//            holds what the memory should contain, and expected read data,
//            address and access spacing are derived from the request rules.
// Config   : SRAM_TURNAROUND_EN selects the expected read turnaround.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_initiator;

    localparam int AW = 4;
    localparam int DW = 16;
`ifdef SRAM_TURNAROUND_EN
    localparam bit c_turn = 1'b1;
`else
    localparam bit c_turn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;

    // Behavioural SRAM device on the bus.
    logic [DW-1:0] dev_mem [16] = '{default: '0};
    // Reference view of memory contents and expected visible state.
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] exp_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_t[$];
    bit prev_valid;
    bit prev_read;
    int prev_t;

    sram_bus_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe)
    );

    always #5 clk = ~clk;

    assign mem_data = (mem_cs && mem_oe) ? dev_mem[mem_addr] : {DW{1'bz}};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_cs && mem_we) dev_mem[mem_addr] <= mem_data;
        if (!rst && req_valid && req_ready) acc_t.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A released bus reads as Z on 4-state simulators and as 0 on 2-state ones.
    function automatic logic bus_free();
        return (mem_data === {DW{1'bz}}) || (mem_data === {DW{1'b0}});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        chk("we_oe_exclusive", 32'(mem_we & mem_oe), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cs"},    32'(mem_cs), 32'd0);
        chk({tag, "_we"},    32'(mem_we), 32'd0);
        chk({tag, "_oe"},    32'(mem_oe), 32'd0);
        chk({tag, "_bus"},   32'(bus_free()), 32'd1);
        chk({tag, "_addr"},  32'(mem_addr), 32'(exp_addr));
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    endtask

    task automatic chk_idle(input string tag);
        chk_quiet(tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    // One full transaction presented in the current IDLE cycle, checked
    // cycle by cycle until the completion pulse has been seen.
    task automatic do_access(input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input bit hold);
        int n0;
        n0        = acc_t.size();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        tick();
        chk("accept", 32'(acc_t.size() - n0), 32'd1);
        if (acc_t.size() > n0) begin
            if (prev_valid)
                chk("spacing", 32'(acc_t[$] - prev_t), (prev_read && c_turn) ? 32'd3 : 32'd2);
            prev_t = acc_t[$];
        end
        prev_valid = 1'b1;
        prev_read  = !we;
        exp_addr   = addr;
        // Access cycle.
        chk("acc_cs",    32'(mem_cs), 32'd1);
        chk("acc_we",    32'(mem_we), 32'(we));
        chk("acc_oe",    32'(mem_oe), 32'(!we));
        chk("acc_addr",  32'(mem_addr), 32'(addr));
        chk("acc_busy",  32'(busy), 32'd1);
        chk("acc_ready", 32'(req_ready), 32'd0);
        chk("acc_rsp",   32'(rsp_valid), 32'd0);
        chk("acc_data",  32'(mem_data), we ? 32'(data) : 32'(ref_mem[addr]));
        if (we) ref_mem[addr] = data;
        else    exp_rdata     = ref_mem[addr];
        // Noise on the request side while busy must be ignored.
        req_valid = hold ? 1'b1 : 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        tick();
        if (!we && c_turn) begin
            chk("turn_rsp",  32'(rsp_valid), 32'd1);
            chk("turn_busy", 32'(busy), 32'd1);
            chk("turn_ready", 32'(req_ready), 32'd0);
            chk_quiet("turn");
            tick();
            chk("post_turn_rsp", 32'(rsp_valid), 32'd0);
        end else begin
            chk("done_rsp", 32'(rsp_valid), 32'd1);
        end
        chk_idle("done");
        chk("no_extra_accept", 32'(acc_t.size() - n0), 32'd1);
        req_valid = hold;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        exp_rdata  = '0;
        exp_addr   = '0;
        prev_valid = 1'b0;
        prev_read  = 1'b0;
        prev_t     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_rsp", 32'(rsp_valid), 32'd0);
        chk_idle("reset");

        // Directed: write then read back, then a held-valid read/write pair.
        do_access(1'b1, 4'd3, 16'hA5A5, 1'b0);
        do_access(1'b0, 4'd3, 16'h0000, 1'b0);
        chk("read_back", 32'(rsp_rdata), 32'hA5A5);
        do_access(1'b1, 4'd15, 16'h5A3C, 1'b0);
        do_access(1'b0, 4'd15, 16'h0000, 1'b1);
        do_access(1'b1, 4'd0, 16'h1234, 1'b0);
        do_access(1'b0, 4'd0, 16'h0000, 1'b0);

        // Reset in the middle of a read aborts it.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd3;
        tick();
        chk("rd_before_rst_oe", 32'(mem_oe), 32'd1);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd9;
        tick();
        exp_rdata  = '0;
        exp_addr   = '0;
        prev_valid = 1'b0;
        chk("rst_rd_rsp", 32'(rsp_valid), 32'd0);
        chk_idle("rst_rd");
        // Request presented while reset is still asserted is not taken.
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        chk("rst_hold_cs", 32'(mem_cs), 32'd0);
        tick();
        chk("rst_req_ignored_busy", 32'(busy), 32'd0);
        chk("rst_req_ignored_rsp",  32'(rsp_valid), 32'd0);
        chk_idle("after_rst");

        // Randomized back-to-back traffic.
        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom), AW'($urandom), DW'($urandom), (i != 39) && 1'($urandom));
        end
        req_valid = 1'b0;
        tick();
        chk("final_rsp", 32'(rsp_valid), 32'd0);
        chk_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_bus_initiator.md
SRAM_BUS_INITIATOR -- requirements
Module: sram_bus_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, address width of request and memory bus.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width of request, response and memory bus.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  initiator accepts a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_WIDTH  target word address.
REQ-009 req_wdata  input  DATA_WIDTH  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse, reads and writes.
REQ-011 rsp_rdata  output  DATA_WIDTH  read data, valid while rsp_valid=1 after a read.
REQ-012 busy  output  1  high in every non-IDLE state.
REQ-013 mem_addr  output  ADDR_WIDTH  memory address.
REQ-014 mem_data  inout  DATA_WIDTH  bidirectional memory data bus.
REQ-015 mem_cs / mem_we / mem_oe  output  1 each  chip select, write enable, output enable.

Function
REQ-016 FSM states SHALL be IDLE, WR, RD, TURN; all memory-side outputs SHALL be registered.
REQ-017 req_ready SHALL equal 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, capturing req_we, req_addr and req_wdata.
REQ-018 On acceptance, next state SHALL be WR if req_we=1, else RD; req_valid while not in IDLE SHALL be ignored.
REQ-019 In WR (one cycle): mem_cs=1, mem_we=1, mem_oe=0, mem_addr=captured address, mem_data driven with captured data; next state IDLE.
REQ-020 In RD (one cycle): mem_cs=1, mem_we=0, mem_oe=1, mem_data high-impedance; at the edge leaving RD, mem_data SHALL be sampled into rsp_rdata.
REQ-021 mem_data SHALL be driven only in WR; high-impedance in IDLE, RD, TURN and during reset.
REQ-022 In IDLE and TURN: mem_cs=0, mem_we=0, mem_oe=0; mem_addr SHALL hold its last value.
REQ-023 mem_we and mem_oe SHALL never be 1 simultaneously.
REQ-024 rsp_valid SHALL be 1 for exactly the cycle after WR or RD; latency from acceptance edge to rsp_valid=1 is 2 edges.
REQ-025 rsp_rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-026 Peak throughput: one access per 2 cycles; after a read with turnaround compiled in, one per 3 cycles.
REQ-027 Addresses 0 to 2^ADDR_WIDTH-1 SHALL be passed unmodified; no increment or wrap logic.

Reset
REQ-028 With rst=1 at a rising edge: state=IDLE, req_ready=1 from the following cycle, rsp_valid=0, rsp_rdata=0, busy=0, mem_addr=0, mem_cs=mem_we=mem_oe=0, mem_data high-impedance.
REQ-029 Reset during WR or RD SHALL abort the access with no rsp_valid pulse, and any request presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-030 Macro SRAM_TURNAROUND_EN defined: RD SHALL go to TURN for one cycle, with all controls low and bus released, before IDLE; rsp_valid SHALL pulse in the TURN cycle.
REQ-031 Macro SRAM_TURNAROUND_EN undefined: TURN SHALL be unreachable and RD SHALL go directly to IDLE.

Verification
REQ-032 Write 0xA5A5 to addr 3: one cycle with mem_cs=1, mem_we=1, mem_oe=0, mem_addr=3, mem_data=0xA5A5; rsp_valid pulses 2 edges after acceptance.
REQ-033 Read addr 3 with memory model returning 0xA5A5: one cycle with mem_cs=1, mem_oe=1, mem_we=0, bus Z from initiator; rsp_rdata=0xA5A5 with rsp_valid.
REQ-034 req_valid held high with read addr 15 then write addr 0: accepts spaced 2 cycles with macro undefined and 3 cycles with macro defined; mem_we and mem_oe never both 1; no bus contention.
REQ-035 rst asserted during RD: next cycle IDLE, all controls 0, bus Z, no rsp_valid, rsp_rdata=0.
REQ-036 req_valid toggled while busy=1: no additional acceptance and mem_addr unchanged until return to IDLE.
